// File: rtl/sum_sequencer.sv
// sum_sequencer: serial summation controller.
// Addends arrive one per valid/ready beat on the input stream. Each one is
// folded into an NBITS accumulator through a single adder. The total is then
// offered on a valid/ready result port.
// Optional build macro SUM_SEQ_SAT_EN: when defined, each accumulate step
// saturates at 2^NBITS-1. When it is undefined, the sum wraps modulo 2^NBITS.
module sum_sequencer #(
  parameter int NBITS    = 3,
  parameter int NADDENDS = 6,
  localparam int CNTW    = (NADDENDS > 0) ? $clog2(NADDENDS + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_sum,
  output logic             busy,
  output logic [CNTW-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Count value of the final addend of a job. ACCUM is never entered when
  // NADDENDS is zero, so the clamp only keeps the constant in range.
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'((NADDENDS > 0) ? NADDENDS - 1 : 0);

  state_t           state;
  logic [NBITS-1:0] acc;
  logic             beat;
  logic [NBITS-1:0] acc_next;

  // One accumulate step. The saturating build widens the sum by one bit and
  // clamps on carry-out. The wrapping build keeps plain NBITS arithmetic.
  function automatic logic [NBITS-1:0] add_step(input logic [NBITS-1:0] a,
                                                input logic [NBITS-1:0] b);
`ifdef SUM_SEQ_SAT_EN
    logic [NBITS:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    return wide[NBITS] ? {NBITS{1'b1}} : wide[NBITS-1:0];
`else
    return a + b;
`endif
  endfunction

  assign beat     = in_valid && (state == ACCUM);
  assign acc_next = add_step(acc, in_data);

  // The handshake outputs are decoded only from the state register, so no
  // combinational path runs from an input to an output.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Main controller: job launch, beat folding, result hand-off, and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      out_sum <= '0;
    end else if (clr) begin
      // Abort wins over everything else. A coincident beat is dropped.
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (NADDENDS == 0) begin
              state   <= DONE;
              out_sum <= '0;
            end else begin
              state <= ACCUM;
              acc   <= '0;
              count <= '0;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_next;
            count <= count + CNTW'(1);
            if (count == LAST_CNT) begin
              state   <= DONE;
              out_sum <= acc_next;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            // A start in the hand-off cycle launches the next job with no
            // idle bubble in between.
            if (start && (NADDENDS > 0)) begin
              state <= ACCUM;
              acc   <= '0;
              count <= '0;
            end else if (start) begin
              state   <= DONE;
              out_sum <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer. A queue-based job model is checked
// against the DUT on every falling edge. Directed scenarios add literal
// expectations, and a randomized phase follows them.
module tb_sum_sequencer;

  localparam int NBITS    = 3;
  localparam int NADDENDS = 6;
  localparam int CNTW     = 3;
  localparam int MAXV     = (1 << NBITS) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic             clr       = 1'b0;
  logic             in_valid  = 1'b0;
  logic [NBITS-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [NBITS-1:0] out_sum;
  logic             busy;
  logic [CNTW-1:0]  count;

  int errors = 0;
  int checks = 0;

  sum_sequencer #(.NBITS(NBITS), .NADDENDS(NADDENDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the total of a job is the plain sum of its addends, wrapped
  // or clamped.
  function automatic int job_total(input int vals[$]);
    int t = 0;
    foreach (vals[i]) t += vals[i];
`ifdef SUM_SEQ_SAT_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t % (MAXV + 1);
`endif
  endfunction

  // Model phases: 0 = waiting for a job, 1 = collecting addends,
  // 2 = holding a result.
  int phase  = 0;
  int addends[$];
  int m_sum  = 0;

  // Advance the model from the inputs sampled at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      addends.delete();
      m_sum = 0;
    end else if (clr) begin
      phase = 0;
      addends.delete();
    end else if (phase == 0) begin
      if (start) begin
        if (NADDENDS == 0) begin phase = 2; m_sum = 0; end
        else begin phase = 1; addends.delete(); end
      end
    end else if (phase == 1) begin
      if (in_valid) begin
        addends.push_back(int'(in_data));
        if (addends.size() == NADDENDS) begin
          phase = 2;
          m_sum = job_total(addends);
        end
      end
    end else begin
      if (out_ready) begin
        if (start) begin phase = 1; addends.delete(); end
        else phase = 0;
      end
    end
  end

  // Compare every DUT output with the model away from the active edge.
  always @(negedge clk) begin
    chk("in_ready",  int'(in_ready),  int'(phase == 1));
    chk("out_valid", int'(out_valid), int'(phase == 2));
    chk("busy",      int'(busy),      int'(phase != 0));
    chk("count",     int'(count),     addends.size());
    chk("out_sum",   int'(out_sum),   m_sum);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_cycles;
  int k;
  int seq2[6] = '{7, 7, 0, 0, 0, 1};

  initial begin
    // Reset state.
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-job after three beats.
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 3'd1;
    repeat (3) step();
    in_valid = 1'b0;
    chk("pre_rst_count", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_in_ready", int'(in_ready), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_count", int'(count), 0);
    chk("async_out_sum", int'(out_sum), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    chk("post_rst_idle", int'(busy), 0);

    // Streaming job 1..6.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = NBITS'(i); step();
    end
    in_valid = 1'b0;
    chk("stream_out_valid", int'(out_valid), 1);
    chk("stream_count", int'(count), 6);
`ifdef SUM_SEQ_SAT_EN
    chk("stream_out_sum", int'(out_sum), 7);
`else
    chk("stream_out_sum", int'(out_sum), 5);
`endif

    // Output backpressure while the producer keeps offering data.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 3'd7;
    repeat (5) begin
      step();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_count", int'(count), 6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_to_idle", int'(busy), 0);

    // Bubbled input: ones on alternate cycles.
    acc_cycles = 0; k = 0;
    start = 1'b1; step(); start = 1'b0;
    while (!out_valid && k < 50) begin
      in_valid = (k % 2 == 0); in_data = 3'd1;
      if (in_ready) acc_cycles++;
      step(); k++;
    end
    in_valid = 1'b0;
    chk("bubble_done", int'(out_valid), 1);
    chk("bubble_accum_cycles", acc_cycles, 11);
    chk("bubble_out_sum", int'(out_sum), 6);

    // Back-to-back: start together with the result handshake.
    start = 1'b1; out_ready = 1'b1; step(); start = 1'b0; out_ready = 1'b0;
    chk("b2b_in_ready", int'(in_ready), 1);
    chk("b2b_count", int'(count), 0);
    foreach (seq2[i]) begin
      in_valid = 1'b1; in_data = NBITS'(seq2[i]); step();
    end
    in_valid = 1'b0;
    chk("b2b_out_valid", int'(out_valid), 1);
    chk("b2b_out_sum", int'(out_sum), 7);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Abort after two beats, an ignored start, then clr with start.
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 3'd2; step(); step(); in_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("ign_start_in_ready", int'(in_ready), 1);
    chk("ign_start_count", int'(count), 2);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_count", int'(count), 0);
    clr = 1'b1; start = 1'b1; step(); clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", int'(busy), 0);

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 1) == 0);
      in_data   = NBITS'($urandom_range(0, MAXV));
      step();
    end
    start = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_sequencer.md
Name: sum_sequencer

Overview:
Time-multiplexed summation controller. It accepts NADDENDS operands one per handshake beat on a valid/ready stream and folds each into an NBITS accumulator through a single adder. When the job completes it presents the total on a valid/ready result port. It is the serial, area-lean counterpart to the combinational tree summer and feeds the same downstream consumers.

Parameters:
NBITS, 3, width of each addend, the accumulator and the result
NADDENDS, 6, addends per job (0 is legal and means the job yields 0 with no beats)
CNTW, derived localparam = $clog2(NADDENDS+1) (minimum 1), width of the beat counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  begin a job; sampled only as stated in Behaviour
clr  input  1  synchronous abort; returns the block to IDLE
in_valid  input  1  addend available
in_ready  output  1  block will accept an addend this cycle
in_data  input  NBITS  addend value
out_valid  output  1  result available
out_ready  input  1  consumer takes the result this cycle
out_sum  output  NBITS  job result
busy  output  1  high whenever state != IDLE
count  output  CNTW  addends accepted so far in the current job

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset (rst_n=0, any state, mid-job included):
  - state=IDLE; acc, count and out_sum = 0.
  - in_ready=0, out_valid=0, busy=0.
- Outputs decoded from registered state, no input-to-output combinational paths:
  - in_ready = (state==ACCUM)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE:
  - start=1 with NADDENDS>0: go to ACCUM; acc<=0, count<=0.
  - start=1 with NADDENDS==0: go to DONE; out_sum<=0.
- ACCUM:
  - Beat accepted iff in_valid && in_ready. On a beat: acc<=acc+in_data, truncated mod 2^NBITS; count<=count+1.
  - No beat: acc and count hold.
  - Beat with count==NADDENDS-1: go to DONE; out_sum<=acc+in_data, same arithmetic.
  - Latency: out_valid rises the cycle after the final beat. A job with no stalls occupies NADDENDS cycles in ACCUM.
- DONE:
  - out_sum and count hold stable until the handshake.
  - out_valid && out_ready: go to IDLE. If start=1 in that same cycle, go directly to ACCUM instead (back-to-back job, no idle bubble); acc<=0, count<=0.
  - out_sum keeps its last value after leaving DONE, until the next job's DONE.
- start while in ACCUM, or in DONE without an out_ready handshake: ignored, no effect.
- clr=1 in any state: go to IDLE next cycle; acc<=0, count<=0, out_sum unchanged.
  - clr has priority over start, beats and the result handshake in that cycle.
  - A beat coinciding with clr is dropped. in_ready was high, so the producer sees it accepted.
- in_data is ignored when in_ready=0.

Optional Feature:
Macro SUM_SEQ_SAT_EN.
- Defined: each accumulate step saturates, acc<=min(acc+in_data, 2^NBITS-1). The addition is computed at NBITS+1 bits, then clamped. out_sum uses the same clamped result.
- Undefined: modulo-2^NBITS wrap as above. No saturation logic is present.
- Ports and timing are identical in both builds.

Test Plan:
- Reset mid-job: NBITS=3, NADDENDS=6, drop rst_n asynchronously after 3 beats -> immediately busy=0, in_ready=0, out_valid=0, count=0, out_sum=0. After release, state is IDLE.
- Streaming job: start, then beats 1,2,3,4,5,6 on consecutive cycles -> out_valid=1 the cycle after beat 6, out_sum=5 (21 mod 8), count=6. With SUM_SEQ_SAT_EN: out_sum=7.
- Bubbled input: six beats of 1 with in_valid low on alternate cycles -> count steps only on handshakes; out_sum=6; ACCUM lasts 11 cycles.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1, in_data=7 -> in_ready=0, out_sum stable, count stays 6. Raise out_ready -> IDLE next cycle.
- Back-to-back: start together with the out_ready handshake -> next cycle in_ready=1, count=0. Second job 7,7,0,0,0,1 -> out_sum=7 (15 mod 8); saturating build also gives 7.
- Abort and ignored start: clr after 2 beats in ACCUM -> IDLE next cycle, count=0. start pulsed during ACCUM -> no effect. clr together with start -> stays IDLE.
